// File: rtl/adc_pll_seq.sv
// adc_pll_seq: power-up / lock sequencer for the 24 MHz -> 16 MHz ADC clock PLL.
// Walks the PLL out of standby and reset, qualifies a synchronised extlock,
// retries on lock timeout and only then releases the ADC-domain reset.
// clr_fail is a one-cycle pulse; en is a level request. There is no
// valid/ready handshake on this block.
module adc_pll_seq #(
  parameter int unsigned RST_CYC     = 16,
  parameter int unsigned LOCK_STABLE = 64,
  parameter int unsigned LOCK_TMO    = 4096,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr_fail,
  input  logic       pll_extlock,
  output logic       pll_reset,
  output logic       pll_stdby,
  output logic       pll_rdy,
  output logic       adc_rst_n,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_cnt
);

  localparam logic [2:0] ST_OFF      = 3'd0;
  localparam logic [2:0] ST_WAKE     = 3'd1;
  localparam logic [2:0] ST_LOCKWAIT = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_FAIL     = 3'd4;

  // Terminal counts: a phase ends on the edge where its counter holds N-1.
  localparam logic [15:0] RST_LAST  = 16'(RST_CYC - 1);
  localparam logic [15:0] STAB_LAST = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] TMO_LAST  = 16'(LOCK_TMO - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  logic        meta_q, lock_s_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] stab_q, stab_d;
  logic [3:0]  retry_q, retry_d;
  logic        lock_lost_q, lock_lost_d;
  logic        lock_drop;
  logic        pll_reset_q, pll_stdby_q, pll_rdy_q, adc_rst_n_q, fail_q;
  logic        pll_reset_d, pll_stdby_d, pll_rdy_d, adc_rst_n_d, fail_d;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Two-flop synchroniser for the asynchronous PLL extlock pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      meta_q   <= pll_extlock;
      lock_s_q <= meta_q;
    end
  end

  // Sequencer next state: FAIL only leaves on clr_fail, otherwise en=0 wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    stab_d    = stab_q;
    retry_d   = retry_q;
    lock_drop = 1'b0;
    if (state_q == ST_FAIL) begin
      if (clr_fail) begin
        state_d = ST_OFF;
        retry_d = '0;
      end
    end else if (!en) begin
      state_d = ST_OFF;
      retry_d = '0;
      cnt_d   = '0;
      tmo_d   = '0;
      stab_d  = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
        ST_WAKE: begin
          if (cnt_q >= RST_LAST) begin
            state_d = ST_LOCKWAIT;
            tmo_d   = '0;
            stab_d  = '0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        ST_LOCKWAIT: begin
          tmo_d  = sat_inc(tmo_q);
          stab_d = lock_s_q ? sat_inc(stab_q) : '0;
          // Lock completion is checked first so it wins a tie with the timeout.
          if (lock_s_q && (stab_q >= STAB_LAST)) begin
            state_d = ST_RUN;
          end else if (tmo_q >= TMO_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 4'd1;
              state_d = ST_WAKE;
              cnt_d   = '0;
            end else begin
              state_d = ST_FAIL;
            end
          end
        end
        ST_RUN: begin
          if (!lock_s_q) begin
            state_d   = ST_WAKE;
            cnt_d     = '0;
            retry_d   = '0;
            lock_drop = 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Sticky lock-lost flag; a fresh drop beats a simultaneous clear.
  always_comb begin
    lock_lost_d = lock_lost_q;
    if (lock_drop) begin
      lock_lost_d = 1'b1;
    end else if (clr_fail) begin
      lock_lost_d = 1'b0;
    end
  end

  // Pin decode of the next state, registered so pins move with the state.
  always_comb begin
    pll_stdby_d = 1'b0;
    pll_reset_d = 1'b0;
    pll_rdy_d   = 1'b0;
    adc_rst_n_d = 1'b0;
    fail_d      = 1'b0;
    case (state_d)
      ST_OFF: begin
        pll_stdby_d = 1'b1;
        pll_reset_d = 1'b1;
      end
      ST_WAKE: pll_reset_d = 1'b1;
      ST_RUN: begin
        pll_rdy_d   = 1'b1;
        adc_rst_n_d = 1'b1;
      end
      ST_FAIL: begin
        pll_stdby_d = 1'b1;
        pll_reset_d = 1'b1;
        fail_d      = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counters, flags and output pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      tmo_q       <= '0;
      stab_q      <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
      pll_stdby_q <= 1'b1;
      pll_reset_q <= 1'b1;
      pll_rdy_q   <= 1'b0;
      adc_rst_n_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      stab_q      <= stab_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
      pll_stdby_q <= pll_stdby_d;
      pll_reset_q <= pll_reset_d;
      pll_rdy_q   <= pll_rdy_d;
      adc_rst_n_q <= adc_rst_n_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_stdby = pll_stdby_q;
  assign pll_reset = pll_reset_q;
  assign pll_rdy   = pll_rdy_q;
  assign adc_rst_n = adc_rst_n_q;
  assign fail      = fail_q;
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_adc_pll_seq.sv
// Testbench for adc_pll_seq: directed scenarios with timing derived from the
// sequencing rules, plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_adc_pll_seq;

  localparam int RST_CYC     = 4;
  localparam int LOCK_STABLE = 8;
  localparam int LOCK_TMO    = 100;
  localparam int MAX_RETRY   = 2;
  localparam int ATTEMPT     = RST_CYC + LOCK_TMO;

  // Model phases (bench-local numbering).
  localparam int PH_OFF  = 10;
  localparam int PH_WAKE = 11;
  localparam int PH_LOCK = 12;
  localparam int PH_RUN  = 13;
  localparam int PH_FAIL = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       clr_fail = 1'b0;
  logic       pll_extlock = 1'b0;
  logic       pll_reset, pll_stdby, pll_rdy, adc_rst_n, fail, lock_lost;
  logic [3:0] retry_cnt;
  logic [9:0] dut_o;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state.
  int ph, m_wake, m_wait, m_streak, m_retry;
  bit m_lost, m_x1, m_x2;

  adc_pll_seq #(
    .RST_CYC    (RST_CYC),
    .LOCK_STABLE(LOCK_STABLE),
    .LOCK_TMO   (LOCK_TMO),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr_fail   (clr_fail),
    .pll_extlock(pll_extlock),
    .pll_reset  (pll_reset),
    .pll_stdby  (pll_stdby),
    .pll_rdy    (pll_rdy),
    .adc_rst_n  (adc_rst_n),
    .fail       (fail),
    .lock_lost  (lock_lost),
    .retry_cnt  (retry_cnt)
  );

  assign dut_o = {pll_stdby, pll_reset, pll_rdy, adc_rst_n, fail, lock_lost, retry_cnt};

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  task automatic model_reset();
    ph = PH_OFF; m_wake = 0; m_wait = 0; m_streak = 0; m_retry = 0;
    m_lost = 1'b0; m_x1 = 1'b0; m_x2 = 1'b0;
  endtask

  // One clock edge: e/c/x are en, clr_fail, extlock as seen at that edge.
  task automatic model_step(input bit e, input bit c, input bit x);
    bit ls, drop;
    ls = m_x2;            // extlock value from two edges ago
    m_x2 = m_x1;
    m_x1 = x;
    drop = 1'b0;
    if (ph == PH_FAIL) begin
      if (c) begin ph = PH_OFF; m_retry = 0; end
    end else if (!e) begin
      ph = PH_OFF; m_retry = 0;
    end else begin
      case (ph)
        PH_OFF: begin ph = PH_WAKE; m_wake = 0; end
        PH_WAKE: begin
          m_wake++;
          if (m_wake == RST_CYC) begin ph = PH_LOCK; m_wait = 0; m_streak = 0; end
        end
        PH_LOCK: begin
          m_wait++;
          m_streak = ls ? m_streak + 1 : 0;
          if (m_streak >= LOCK_STABLE) ph = PH_RUN;
          else if (m_wait >= LOCK_TMO) begin
            if (m_retry < MAX_RETRY) begin m_retry++; ph = PH_WAKE; m_wake = 0; end
            else ph = PH_FAIL;
          end
        end
        PH_RUN: if (!ls) begin ph = PH_WAKE; m_wake = 0; m_retry = 0; drop = 1'b1; end
        default: ;
      endcase
    end
    if (drop) m_lost = 1'b1;
    else if (c) m_lost = 1'b0;
  endtask

  function automatic logic [9:0] model_outs();
    logic s, r, y, f;
    s = 1'b0; r = 1'b0; y = 1'b0; f = 1'b0;
    case (ph)
      PH_OFF:  begin s = 1'b1; r = 1'b1; end
      PH_WAKE: r = 1'b1;
      PH_RUN:  y = 1'b1;
      PH_FAIL: begin s = 1'b1; r = 1'b1; f = 1'b1; end
      default: ;
    endcase
    return {s, r, y, y, f, m_lost, 4'(m_retry)};
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs are captured before the edge, outputs settle 1ns after.
  task automatic clk_step();
    bit e, c, x;
    e = en; c = clr_fail; x = pll_extlock;
    @(posedge clk);
    model_step(e, c, x);
    #1;
  endtask

  task automatic go_idle();
    en = 1'b0;
    pll_extlock = 1'b0;
    clr_fail = 1'b1;
    clk_step();
    clr_fail = 1'b0;
    repeat (3) clk_step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (dut_o !== 10'b11_0000_0000)
      $display("FAIL reset_async_entry: outputs=%b, expected 1100000000", dut_o);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (dut_o !== 10'b11_0000_0000)
      $display("FAIL reset_held: outputs=%b, expected 1100000000", dut_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) clk_step();
    n_total++;
    if (dut_o !== 10'b11_0000_0000)
      $display("FAIL reset_idle_off: outputs=%b, expected 1100000000", dut_o);
    else n_pass++;
  endtask

  task automatic test_nominal();
    logic exp_reset, exp_rdy;
    go_idle();
    en = 1'b1;  // cycle 0
    for (int c = 1; c <= 24; c++) begin
      clk_step();
      exp_reset = (c <= RST_CYC);
      exp_rdy   = (c >= 10 + 2 + LOCK_STABLE);
      n_total++;
      if (pll_stdby !== 1'b0 || pll_reset !== exp_reset)
        $display("FAIL nominal_pll_pins cycle %0d: stdby=%b reset=%b, expected stdby=0 reset=%b",
                 c, pll_stdby, pll_reset, exp_reset);
      else n_pass++;
      n_total++;
      if (pll_rdy !== exp_rdy || adc_rst_n !== exp_rdy || retry_cnt !== 4'd0)
        $display("FAIL nominal_ready cycle %0d: rdy=%b adc_rst_n=%b retry=%0d, expected rdy=%b adc_rst_n=%b retry=0",
                 c, pll_rdy, adc_rst_n, retry_cnt, exp_rdy, exp_rdy);
      else n_pass++;
      if (c == 10) pll_extlock = 1'b1;
    end
  endtask

  task automatic test_glitchy();
    int first_rdy;
    go_idle();
    en = 1'b1;
    first_rdy = -1;
    for (int c = 1; c <= 90; c++) begin
      clk_step();
      if (pll_rdy === 1'b1 && first_rdy < 0) first_rdy = c;
      n_total++;
      if (dut_o !== model_outs())
        $display("FAIL glitchy_model cycle %0d: outputs=%b, expected %b", c, dut_o, model_outs());
      else n_pass++;
      if (c >= 5 && c < 65) pll_extlock = (((c - 5) / 5) % 2 == 0);
      else if (c >= 65) pll_extlock = 1'b1;
    end
    n_total++;
    if (first_rdy != 65 + 2 + LOCK_STABLE)
      $display("FAIL glitchy_first_ready: pll_rdy rose at cycle %0d, expected %0d", first_rdy, 65 + 2 + LOCK_STABLE);
    else n_pass++;
    n_total++;
    if (retry_cnt !== 4'd0)
      $display("FAIL glitchy_retry: retry_cnt=%0d, expected 0", retry_cnt);
    else n_pass++;
  endtask

  task automatic test_never_locks();
    int fail_at, exp_retry;
    logic exp_fail;
    go_idle();
    en = 1'b1;
    fail_at = 1 + (MAX_RETRY + 1) * ATTEMPT;
    for (int c = 1; c <= fail_at + 2; c++) begin
      clk_step();
      exp_retry = (c - 1) / ATTEMPT;
      if (exp_retry > MAX_RETRY) exp_retry = MAX_RETRY;
      exp_fail = (c >= fail_at);
      n_total++;
      if (retry_cnt !== 4'(exp_retry) || fail !== exp_fail || pll_stdby !== exp_fail)
        $display("FAIL nolock_progress cycle %0d: retry=%0d fail=%b stdby=%b, expected retry=%0d fail=%b stdby=%b",
                 c, retry_cnt, fail, pll_stdby, exp_retry, exp_fail, exp_fail);
      else n_pass++;
    end
    for (int i = 0; i < 20; i++) begin
      en = 1'($urandom_range(0, 1));
      clk_step();
      n_total++;
      if (fail !== 1'b1 || pll_stdby !== 1'b1 || pll_reset !== 1'b1 || retry_cnt !== 4'(MAX_RETRY))
        $display("FAIL nolock_en_ignored: fail=%b stdby=%b reset=%b retry=%0d, expected 1 1 1 %0d",
                 fail, pll_stdby, pll_reset, retry_cnt, MAX_RETRY);
      else n_pass++;
    end
    en = 1'b1;
    clr_fail = 1'b1;
    clk_step();
    clr_fail = 1'b0;
    n_total++;
    if (fail !== 1'b0 || retry_cnt !== 4'd0 || pll_stdby !== 1'b1 || pll_reset !== 1'b1)
      $display("FAIL nolock_clear: fail=%b retry=%0d stdby=%b reset=%b, expected 0 0 1 1",
               fail, retry_cnt, pll_stdby, pll_reset);
    else n_pass++;
    clk_step();
    n_total++;
    if (pll_stdby !== 1'b0 || pll_reset !== 1'b1)
      $display("FAIL nolock_restart: stdby=%b reset=%b, expected stdby=0 reset=1", pll_stdby, pll_reset);
    else n_pass++;
  endtask

  task automatic test_lock_loss();
    bit got;
    go_idle();
    en = 1'b1;
    pll_extlock = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin clk_step(); got = pll_rdy; end
    n_total++;
    if (!got || lock_lost !== 1'b0)
      $display("FAIL loss_first_lock: rdy=%b lock_lost=%b, expected rdy=1 lock_lost=0", pll_rdy, lock_lost);
    else n_pass++;
    repeat (5) clk_step();
    pll_extlock = 1'b0;
    for (int d = 1; d <= 3; d++) begin
      clk_step();
      if (d < 3) begin
        n_total++;
        if (pll_rdy !== 1'b1 || adc_rst_n !== 1'b1)
          $display("FAIL loss_latency d=%0d: rdy=%b adc_rst_n=%b, expected 1 1", d, pll_rdy, adc_rst_n);
        else n_pass++;
      end
    end
    n_total++;
    if (pll_rdy !== 1'b0 || adc_rst_n !== 1'b0 || lock_lost !== 1'b1 || pll_stdby !== 1'b0 ||
        pll_reset !== 1'b1 || retry_cnt !== 4'd0)
      $display("FAIL loss_drop: rdy=%b adc=%b lost=%b stdby=%b reset=%b retry=%0d, expected 0 0 1 0 1 0",
               pll_rdy, adc_rst_n, lock_lost, pll_stdby, pll_reset, retry_cnt);
    else n_pass++;
    pll_extlock = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin clk_step(); got = pll_rdy; end
    n_total++;
    if (!got || lock_lost !== 1'b1)
      $display("FAIL loss_relock: rdy=%b lock_lost=%b, expected rdy=1 lock_lost=1", pll_rdy, lock_lost);
    else n_pass++;
    clr_fail = 1'b1;
    clk_step();
    clr_fail = 1'b0;
    n_total++;
    if (lock_lost !== 1'b0 || pll_rdy !== 1'b1)
      $display("FAIL loss_clear: lock_lost=%b rdy=%b, expected 0 1", lock_lost, pll_rdy);
    else n_pass++;
    // Drop detected on the same edge as a clear: the drop must win.
    pll_extlock = 1'b0;
    repeat (2) clk_step();
    clr_fail = 1'b1;
    clk_step();
    clr_fail = 1'b0;
    n_total++;
    if (lock_lost !== 1'b1 || pll_rdy !== 1'b0)
      $display("FAIL loss_drop_beats_clear: lock_lost=%b rdy=%b, expected 1 0", lock_lost, pll_rdy);
    else n_pass++;
  endtask

  task automatic test_disable();
    go_idle();
    en = 1'b1;
    repeat (2) clk_step();  // now in WAKE cycle 2
    en = 1'b0;
    clk_step();
    n_total++;
    if (pll_stdby !== 1'b1 || pll_reset !== 1'b1 || retry_cnt !== 4'd0 || pll_rdy !== 1'b0)
      $display("FAIL disable_wake: stdby=%b reset=%b retry=%0d rdy=%b, expected 1 1 0 0",
               pll_stdby, pll_reset, retry_cnt, pll_rdy);
    else n_pass++;
    repeat (3) clk_step();
    en = 1'b1;
    for (int c = 1; c <= 120; c++) clk_step();
    n_total++;
    if (pll_stdby !== 1'b0 || pll_reset !== 1'b0 || retry_cnt !== 4'd1)
      $display("FAIL disable_pre_lockwait: stdby=%b reset=%b retry=%0d, expected 0 0 1",
               pll_stdby, pll_reset, retry_cnt);
    else n_pass++;
    en = 1'b0;
    clk_step();
    n_total++;
    if (pll_stdby !== 1'b1 || pll_reset !== 1'b1 || retry_cnt !== 4'd0)
      $display("FAIL disable_lockwait: stdby=%b reset=%b retry=%0d, expected 1 1 0",
               pll_stdby, pll_reset, retry_cnt);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bit got;
    go_idle();
    en = 1'b1;
    pll_extlock = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin clk_step(); got = pll_rdy; end
    n_total++;
    if (!got)
      $display("FAIL areset_lock: rdy=%b after 60 cycles, expected 1", pll_rdy);
    else n_pass++;
    #2 rst_n = 1'b0;  // between edges
    #1;
    n_total++;
    if (dut_o !== 10'b11_0000_0000)
      $display("FAIL areset_immediate: outputs=%b, expected 1100000000", dut_o);
    else n_pass++;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    clk_step();
    n_total++;
    if (pll_stdby !== 1'b0 || pll_reset !== 1'b1 || pll_rdy !== 1'b0)
      $display("FAIL areset_restart: stdby=%b reset=%b rdy=%b, expected 0 1 0", pll_stdby, pll_reset, pll_rdy);
    else n_pass++;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin clk_step(); got = pll_rdy; end
    n_total++;
    if (!got)
      $display("FAIL areset_relock: rdy=%b after 60 cycles, expected 1", pll_rdy);
    else n_pass++;
  endtask

  task automatic test_random();
    int hold;
    go_idle();
    en = 1'b1;
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 19) == 0) begin
          pll_extlock = 1'b0;
          hold = $urandom_range(100, 400);
        end else begin
          pll_extlock = ($urandom_range(0, 3) != 0);
          hold = $urandom_range(1, 40);
        end
      end else hold--;
      if (en && $urandom_range(0, 199) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      clr_fail = ($urandom_range(0, 99) == 0);
      clk_step();
      n_total++;
      if (dut_o !== model_outs())
        $display("FAIL random_model cycle %0d: outputs=%b, expected %b", c, dut_o, model_outs());
      else n_pass++;
    end
    clr_fail = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_nominal();
    test_glitchy();
    test_never_locks();
    test_lock_loss();
    test_disable();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adc_pll_seq.md
Name: adc_pll_seq

Overview:
- Power-up/lock sequencer for the ADC clock PLL (24 MHz ref -> 16 MHz ADC clock).
- Drives the PLL stdby/reset pins, qualifies extlock and retries on lock timeout.
- Releases the ADC-domain reset only once the clock is stable, and reports hard failure.
- Runs on the 24 MHz system clock; sits between the ADC control registers and the PLL primitive.

Parameters:
RST_CYC, 16, cycles pll_reset is held high after leaving standby (1..65535)
LOCK_STABLE, 64, consecutive synced-extlock-high cycles required to declare lock (1..65535)
LOCK_TMO, 4096, max cycles in LOCKWAIT before an attempt is abandoned (> LOCK_STABLE)
MAX_RETRY, 3, retries after the first attempt before FAIL (0..15)

Ports:
clk  in  1  system clock, 24 MHz, same source as PLL refclk
rst_n  in  1  asynchronous active-low reset
en  in  1  ADC clock request (level)
clr_fail  in  1  single-cycle pulse: leave FAIL / clear lock_lost
pll_extlock  in  1  PLL extlock, asynchronous to clk
pll_reset  out  1  to PLL reset
pll_stdby  out  1  to PLL stdby
pll_rdy  out  1  ADC clock usable
adc_rst_n  out  1  ADC-domain reset, active low; receiver re-synchronises it
fail  out  1  lock never achieved within retries
lock_lost  out  1  sticky: lock dropped while in RUN
retry_cnt  out  4  retries consumed in the current bring-up

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- During reset and after it: state OFF, pll_stdby=1, pll_reset=1, pll_rdy=0, adc_rst_n=0, fail=0, lock_lost=0, retry_cnt=0, counters 0.
- pll_extlock passes through a 2-flop synchroniser -> lock_s, giving 2 cycles of latency.
- All outputs are registered and decoded from the state register, so they change on the same edge as the state.
- OFF: stdby=1, reset=1.
  - en=1 -> WAKE; cnt=0.
- WAKE: stdby=0, reset=1.
  - Lasts exactly RST_CYC cycles, then -> LOCKWAIT.
  - On entering LOCKWAIT, tmo and stab counters are cleared.
- LOCKWAIT: stdby=0, reset=0.
  - stab increments while lock_s=1 and clears when lock_s=0.
  - tmo increments every cycle.
  - stab reaching LOCK_STABLE -> RUN.
  - tmo reaching LOCK_TMO without lock:
    - retry_cnt<MAX_RETRY -> retry_cnt+1, go to WAKE.
    - otherwise -> FAIL.
  - If stab completes on the same cycle tmo expires, lock wins (-> RUN).
- RUN: stdby=0, reset=0, pll_rdy=1, adc_rst_n=1; retry_cnt holds its value.
  - lock_s=0 -> WAKE next edge; pll_rdy and adc_rst_n drop on that edge.
  - A lock drop also sets lock_lost and clears retry_cnt.
- FAIL: stdby=1, reset=1, pll_rdy=0, adc_rst_n=0, fail=1.
  - en is ignored.
  - clr_fail -> OFF, with fail=0 and retry_cnt=0.
- en=0 in any state except FAIL -> OFF next edge, retry_cnt=0.
  - This applies mid-WAKE and mid-LOCKWAIT too.
  - en=0 has priority over every other transition.
- clr_fail clears lock_lost in any state; a new lock drop on the same cycle wins (flag stays set).
- Counters are 16 bits and saturate; they never wrap.
- rst_n asserted mid-operation returns everything to reset values immediately (asynchronously).

Test Plan:
Common settings: RST_CYC=4, LOCK_STABLE=8, LOCK_TMO=100, MAX_RETRY=2.
1. Nominal bring-up: en=1 at cycle 0, extlock high from cycle 10 -> pll_stdby falls at cycle 1; pll_reset high for cycles 1-4; pll_rdy=adc_rst_n=1 exactly 2+8 cycles after extlock rises; retry_cnt=0.
2. Glitchy lock: extlock toggles every 5 cycles for 60 cycles, then steady -> no RUN until 8 consecutive synced-high cycles; no retry consumed.
3. Never locks: extlock=0 -> three WAKE/LOCKWAIT attempts (retry_cnt 0,1,2), then fail=1 and stdby=1; en toggling is ignored; clr_fail -> OFF, fail=0; en still 1 -> new bring-up.
4. Lock loss in RUN: drop extlock -> pll_rdy/adc_rst_n low 3 cycles later, lock_lost=1, re-enters WAKE, relocks; clr_fail clears lock_lost.
5. Disable mid-sequence: en=0 during WAKE cycle 2, and again during LOCKWAIT -> OFF next edge, stdby=1, retry_cnt=0.
6. Async reset in RUN: rst_n low between edges -> all outputs at reset values immediately, without waiting for a clk edge; after release, bring-up restarts from OFF.
